// File: rtl/parity_link_pkg.sv
// parity_link_pkg: types and helpers shared by both ends of the odd-parity serial link
//   DATA_BITS  : payload bits per frame
//   state_t    : receiver frame states
//   odd_parity : parity bit that makes data plus parity hold an odd number of ones
package parity_link_pkg;
   localparam int DATA_BITS = 8;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
   function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
      return ~^data;
   endfunction
endpackage

// File: rtl/parity_rx_sync.sv
// parity_rx_sync: 2-flop synchronizer for the serial line plus falling-edge detect
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   sin_i  : raw serial line, asynchronous to clk_i
//   line_o : synchronized line (resets to 1)
//   fall_o : synchronized line went 1 -> 0 this cycle
module parity_rx_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sin_i,
   output logic line_o,
   output logic fall_o
);
   logic       meta_q, line_q, prev_q;
   logic [1:0] arm_q;
   // arm_q marks when line_q holds a real sample rather than its reset value, so a
   // line already low at reset release is never taken for a falling edge
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b1;
         line_q <= 1'b1;
         prev_q <= 1'b0;
         arm_q  <= 2'b00;
      end else begin
         meta_q <= sin_i;
         line_q <= meta_q;
         prev_q <= line_q & arm_q[1];
         arm_q  <= {arm_q[0], 1'b1};
      end
   end
   assign line_o = line_q;
   assign fall_o = prev_q & ~line_q;
endmodule

// File: rtl/parity_serial_rx.sv
// parity_serial_rx: odd-parity serial receiver (start, 8 data, parity, stop)
//   CLK   : system clock
//   RSTN  : asynchronous active-low reset
//   SIN   : serial line, idle high
//   DOUT  : received byte, DOUT[0] is the first data bit on the line
//   VALID : one-cycle pulse when DOUT/PERR/FERR update
//   PERR  : parity error on the last reported frame
//   FERR  : framing error (stop bit low) on the last reported frame
//   BUSY  : frame in progress (any state other than IDLE)
module parity_serial_rx
   import parity_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 CLK,
   input  logic                 RSTN,
   input  logic                 SIN,
   output logic [0:DATA_BITS-1] DOUT,
   output logic                 VALID,
   output logic                 PERR,
   output logic                 FERR,
   output logic                 BUSY
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   logic                 line, fall, tick;
   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           idx_q, idx_d;
   logic [0:DATA_BITS-1] shift_q, shift_d, dout_q, dout_d;
   logic                 par_q, par_d, valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
   parity_rx_sync u_sync (
      .clk_i  (CLK),
      .rst_ni (RSTN),
      .sin_i  (SIN),
      .line_o (line),
      .fall_o (fall)
   );
   // START waits half a bit to land mid-bit; every later sample is a full bit apart
   assign tick = cnt_q == (state_q == START ? HALF_LAST : BIT_LAST);
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) state_q <= IDLE;
      else       state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = fall ? START : IDLE;
         START:   state_d = tick ? (line ? IDLE : DATA) : START;
         DATA:    state_d = (tick && idx_q == 3'd7) ? PARITY : DATA;
         PARITY:  state_d = tick ? STOP : PARITY;
         STOP:    state_d = tick ? (line ? IDLE : BREAK) : STOP;
         BREAK:   state_d = line ? IDLE : BREAK;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      cnt_d   = (state_q == IDLE || state_q == BREAK || tick) ? '0 : cnt_q + CW'(1);
      idx_d   = state_q == START ? 3'd0 :
                (state_q == DATA && tick && idx_q != 3'd7) ? idx_q + 3'd1 : idx_q;
      shift_d = shift_q;
      if (state_q == DATA && tick) shift_d[idx_q] = line;
      par_d   = (state_q == PARITY && tick) ? line : par_q;
      valid_d = state_q == STOP && tick;
      dout_d  = valid_d ? shift_q : dout_q;
      perr_d  = valid_d ? par_q != odd_parity(shift_q) : perr_q;
      ferr_d  = valid_d ? ~line : ferr_q;
   end
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         shift_q <= '0;
         par_q   <= 1'b0;
         valid_q <= 1'b0;
         dout_q  <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         valid_q <= valid_d;
         dout_q  <= dout_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end
   always_comb begin
      BUSY  = state_q != IDLE;
      DOUT  = dout_q;
      VALID = valid_q;
      PERR  = perr_q;
      FERR  = ferr_q;
   end
endmodule

// File: tb/tb_parity_serial_rx.sv
// tb_parity_serial_rx: scoreboard bench for parity_serial_rx at 16 clocks per bit
module tb_parity_serial_rx;
   localparam int CPB = 16;
   typedef struct packed {
      logic [0:7] d;
      logic       p;
      logic       f;
   } exp_t;
   logic       CLK = 1'b0, RSTN = 1'b0, SIN = 1'b1;
   logic [0:7] DOUT;
   logic       VALID, PERR, FERR, BUSY;
   exp_t       sb[$];
   int         checks = 0, fails = 0, cyc = 0, vcount = 0, last_vcyc = 0, prev_vcyc = 0;
   logic       prev_valid = 1'b0, valid_busy = 1'b0;
   parity_serial_rx #(.CLKS_PER_BIT(CPB)) dut (
      .CLK   (CLK),
      .RSTN  (RSTN),
      .SIN   (SIN),
      .DOUT  (DOUT),
      .VALID (VALID),
      .PERR  (PERR),
      .FERR  (FERR),
      .BUSY  (BUSY)
   );
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;
   task automatic wait_cycles(input int n);
      repeat (n) @(posedge CLK);
      #2;
   endtask
   // PERR expected when data plus parity bit hold an even number of ones
   task automatic expect_frame(input logic [0:7] d, input logic p, input logic f);
      exp_t e;
      e.d = d;
      e.p = ~^{d, p};
      e.f = f;
      sb.push_back(e);
   endtask
   task automatic send_frame(input logic [0:7] d, input logic p, input logic s, input int stop_len);
      SIN = 1'b0;
      wait_cycles(CPB);
      for (int k = 0; k < 8; k++) begin
         SIN = d[k];
         wait_cycles(CPB);
      end
      SIN = p;
      wait_cycles(CPB);
      SIN = s;
      wait_cycles(stop_len);
   endtask
   task automatic monitor_step();
      exp_t e;
      if (VALID) begin
         checks++;
         if (prev_valid) begin
            fails++;
            $display("FAIL valid_consecutive: VALID high at cycle %0d and the cycle before", cyc);
         end
         checks++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_valid: VALID at cycle %0d with no frame expected", cyc);
         end else begin
            e = sb.pop_front();
            checks += 3;
            if (DOUT !== e.d) begin
               fails++;
               $display("FAIL dout: got %h expected %h at cycle %0d", DOUT, e.d, cyc);
            end
            if (PERR !== e.p) begin
               fails++;
               $display("FAIL perr: got %b expected %b for byte %h", PERR, e.p, e.d);
            end
            if (FERR !== e.f) begin
               fails++;
               $display("FAIL ferr: got %b expected %b for byte %h", FERR, e.f, e.d);
            end
         end
         prev_vcyc  = last_vcyc;
         last_vcyc  = cyc;
         valid_busy = BUSY;
         vcount++;
      end
      prev_valid = VALID;
   endtask
   task automatic test_reset();
      RSTN = 1'b0;
      SIN  = 1'b1;
      wait_cycles(3);
      checks += 5;
      if (DOUT !== 8'h00) begin fails++; $display("FAIL reset_dout: got %h expected 00", DOUT); end
      if (VALID !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", VALID); end
      if (PERR !== 1'b0) begin fails++; $display("FAIL reset_perr: got %b expected 0", PERR); end
      if (FERR !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b expected 0", FERR); end
      if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
      RSTN = 1'b1;
      wait_cycles(5);
      checks++;
      if (BUSY !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", BUSY); end
   endtask
   task automatic test_good_frame();
      int v0 = vcount, t0 = cyc;
      expect_frame(8'hA5, 1'b1, 1'b0);
      send_frame(8'hA5, 1'b1, 1'b1, CPB);
      checks += 3;
      if (vcount != v0 + 1) begin fails++; $display("FAIL good_count: got %0d VALIDs expected 1", vcount - v0); end
      if (last_vcyc - t0 != 171) begin fails++; $display("FAIL good_latency: got %0d cycles expected 171", last_vcyc - t0); end
      if (valid_busy !== 1'b0) begin fails++; $display("FAIL busy_at_valid: got %b expected 0", valid_busy); end
   endtask
   task automatic test_parity_error();
      int v0 = vcount;
      expect_frame(8'h3C, 1'b0, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b1, CPB);
      wait_cycles(30);
      checks += 2;
      if (vcount != v0 + 1) begin fails++; $display("FAIL perr_count: got %0d VALIDs expected 1", vcount - v0); end
      if ({DOUT, PERR, FERR} !== {8'h3C, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL perr_hold: got %h/%b/%b expected 3c/1/0", DOUT, PERR, FERR);
      end
   endtask
   task automatic test_framing();
      int v0 = vcount;
      expect_frame(8'h00, 1'b1, 1'b1);
      send_frame(8'h00, 1'b1, 1'b0, 40);
      checks += 2;
      if (vcount != v0 + 1) begin fails++; $display("FAIL break_count: got %0d VALIDs expected 1", vcount - v0); end
      if (BUSY !== 1'b1) begin fails++; $display("FAIL busy_in_break: got %b expected 1", BUSY); end
      SIN = 1'b1;
      wait_cycles(CPB);
      checks++;
      if (BUSY !== 1'b0) begin fails++; $display("FAIL break_exit: got BUSY %b expected 0", BUSY); end
      expect_frame(8'hFF, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b1, CPB);
      checks++;
      if (vcount != v0 + 2) begin fails++; $display("FAIL after_break_count: got %0d VALIDs expected 2", vcount - v0); end
   endtask
   task automatic test_glitch();
      int v0 = vcount;
      SIN = 1'b0;
      wait_cycles(3);
      checks++;
      if (BUSY !== 1'b1) begin fails++; $display("FAIL glitch_busy_rise: got %b expected 1", BUSY); end
      wait_cycles(2);
      SIN = 1'b1;
      wait_cycles(5);
      checks++;
      if (BUSY !== 1'b1) begin fails++; $display("FAIL glitch_busy_hold: got %b expected 1", BUSY); end
      wait_cycles(1);
      checks++;
      if (BUSY !== 1'b0) begin fails++; $display("FAIL glitch_busy_fall: got %b expected 0", BUSY); end
      wait_cycles(200);
      checks++;
      if (vcount != v0) begin fails++; $display("FAIL glitch_valid: got %0d VALIDs expected 0", vcount - v0); end
   endtask
   task automatic test_back_to_back();
      int v0 = vcount;
      expect_frame(8'h55, 1'b1, 1'b0);
      expect_frame(8'hAA, 1'b1, 1'b0);
      send_frame(8'h55, 1'b1, 1'b1, CPB);
      send_frame(8'hAA, 1'b1, 1'b1, CPB);
      checks += 2;
      if (vcount != v0 + 2) begin fails++; $display("FAIL b2b_count: got %0d VALIDs expected 2", vcount - v0); end
      if (last_vcyc - prev_vcyc != 176) begin fails++; $display("FAIL b2b_spacing: got %0d cycles expected 176", last_vcyc - prev_vcyc); end
   endtask
   task automatic test_reset_midframe();
      logic [0:7] d = 8'hC3;
      int v0 = vcount;
      SIN = 1'b0;
      wait_cycles(CPB);
      for (int k = 0; k < 4; k++) begin
         SIN = d[k];
         wait_cycles(CPB);
      end
      SIN = d[4];
      wait_cycles(8);
      RSTN = 1'b0;
      wait_cycles(2);
      checks++;
      if ({DOUT, VALID, PERR, FERR, BUSY} !== 12'h000) begin
         fails++;
         $display("FAIL mid_reset_outputs: got %h/%b/%b/%b/%b expected 00/0/0/0/0", DOUT, VALID, PERR, FERR, BUSY);
      end
      wait_cycles(4);
      RSTN = 1'b1;
      wait_cycles(24);
      checks++;
      if (BUSY !== 1'b0) begin fails++; $display("FAIL low_after_reset: got BUSY %b expected 0", BUSY); end
      SIN = 1'b1;
      wait_cycles(2 * CPB);
      expect_frame(8'h81, 1'b1, 1'b0);
      send_frame(8'h81, 1'b1, 1'b1, CPB);
      checks++;
      if (vcount != v0 + 1) begin fails++; $display("FAIL mid_reset_count: got %0d VALIDs expected 1", vcount - v0); end
   endtask
   initial begin
      fork
         forever begin
            @(posedge CLK);
            #1;
            monitor_step();
         end
      join_none
      test_reset();
      test_good_frame();
      test_parity_error();
      test_framing();
      test_glitch();
      test_back_to_back();
      test_reset_midframe();
      wait_cycles(20);
      checks++;
      if (sb.size() != 0) begin fails++; $display("FAIL sb_leftover: %0d frames never reported, expected 0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/parity_serial_rx.md
# parity_serial_rx

Receive end of the team's odd-parity serial link: deserialises one frame (start, 8 data bits, odd-parity bit, stop) from a single asynchronous line. Presents the data byte with parity-error and framing-error flags. It sits between the off-chip serial pin and the memory/checker path, so received words re-enter the design already parity-checked.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range 4..1023.
- CLK  input  1  system clock, all state on rising edge
- RSTN  input  1  asynchronous, active-low reset
- SIN  input  1  serial line, asynchronous to CLK, idle high
- DOUT  output  [0:7]  received byte; DOUT[0] is the first data bit on the line
- VALID  output  1  one-cycle pulse: DOUT/PERR/FERR updated this cycle
- PERR  output  1  parity error on the frame reported by the last VALID
- FERR  output  1  framing error (stop bit sampled low) on that frame
- BUSY  output  1  high from accepted start edge until return to IDLE

## Operation
- Odd parity: the 8 data bits plus the parity bit must contain an odd number of ones; otherwise PERR=1.
- SIN passes through a 2-flop synchronizer (reset value 1) before any use; "line" below means the synchronized value.
- States:
  - IDLE: wait for line 1->0 (edge vs. previous synchronized sample).
  - START: count HALF = CLKS_PER_BIT/2 (floor); sample the line. Low -> DATA. High -> glitch; return to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT; shift into DOUT index 0..7 in arrival order; after the 8th sample -> PARITY.
  - PARITY: sample after CLKS_PER_BIT -> STOP.
  - STOP: sample after CLKS_PER_BIT; pulse VALID next cycle.
    - High: -> IDLE.
    - Low: FERR=1; -> BREAK.
  - BREAK: wait for line high, then -> IDLE. A low line in BREAK never starts a frame.
- DOUT, PERR and FERR update only in the VALID cycle and hold until the next VALID. A frame with FERR still reports DOUT and PERR.
- Counters: bit-timer width is clog2(CLKS_PER_BIT); bit index is 3 bits and never wraps past 7.

## Timing
- Reset values: DOUT=8'h00, VALID=0, PERR=0, FERR=0, BUSY=0; state IDLE; synchronizer 1s.
- Edge seen at synchronized cycle t:
  - Start sample at t+HALF.
  - Data bit k sample at t+HALF+(k+1)·CLKS_PER_BIT.
  - Parity sample at t+HALF+9·CLKS_PER_BIT.
  - Stop sample at t+HALF+10·CLKS_PER_BIT.
  - VALID at stop sample +1.
- Latency from SIN pin edge to synchronized edge: 2 cycles.
- BUSY rises the cycle after edge detection and falls with entry to IDLE, i.e. the VALID cycle for a good stop bit.
- Back-to-back frames: a new start edge is accepted on the first IDLE cycle after VALID; no idle bit is required beyond the stop bit.
- RSTN low mid-frame: immediate return to reset values. The partial frame is discarded with no VALID. After release, a line already low is not an edge; the receiver waits for high-then-low.
- VALID is never asserted for two consecutive cycles.

## Structure
- Shared package parity_link_pkg:
  - State enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - DATA_BITS=8.
  - Function odd_parity(byte) returning the required parity bit. This function is shared with the transmit-side generator.
- One sub-module, parity_rx_sync: 2-flop synchronizer plus falling-edge detect; reset to 1.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- Frame 8'hA5 with parity bit 1 and stop 1 -> one VALID, DOUT=8'hA5, PERR=0, FERR=0; VALID exactly 2+8+160+1 cycles after the SIN fall.
- Frame 8'h3C with parity bit forced 0 -> VALID, DOUT=8'h3C, PERR=1, FERR=0.
- Frame 8'h00 (parity 1) with stop held low 40 cycles, then high, then frame 8'hFF -> first VALID with FERR=1. No VALID during the low period. Second VALID gives DOUT=8'hFF, PERR=0, FERR=0.
- SIN low pulse of 5 cycles in IDLE -> no VALID, BUSY drops after HALF, state returns to IDLE.
- Back-to-back 8'h55 and 8'hAA with no idle gap -> two VALIDs exactly 176 cycles apart, both error-free.
- RSTN pulsed low during data bit 4 of 8'hC3, then a full frame 8'h81 -> outputs at reset values during reset, no VALID for the aborted frame, then a single VALID with DOUT=8'h81.
